// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus
// and assembles them into a full word with per-digit error flags.
module seg_scan_decoder #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDIG-1:0]   an,
  input  logic [6:0]        seg,
  output logic [4*NDIG-1:0] value,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [NDIG-1:0]   digit_err
);

  localparam int CW = 8;
  localparam logic [CW-1:0] SMAX = CW'(STABLE_CYCLES);

  logic [NDIG-1:0]   an_q;
  logic [NDIG-1:0]   an_p;
  logic [6:0]        seg_q;
  logic [6:0]        seg_p;
  logic [CW-1:0]     cnt;
  logic              dwell;
  logic [NDIG-1:0]   mask;
  logic [NDIG-1:0]   sbad;
  logic [4*NDIG-1:0] snib;

  logic [NDIG-1:0] sel;
  logic            onehot;
  logic            same;
  logic            cap;
  logic            done;
  logic [3:0]      dnib;
  logic            dbad;

  assign sel    = ~an_q;
  assign onehot = (sel != '0) && ((sel & (sel - NDIG'(1))) == '0);
  assign same   = (an_q == an_p) && (seg_q == seg_p);
  assign cap    = onehot && same && !dwell && (cnt == SMAX);
  assign done   = &mask;

  always_comb begin
    dnib = 4'h0;
    dbad = 1'b0;
    case (seg_q)
      7'b1000000: dnib = 4'h0;
      7'b1111001: dnib = 4'h1;
      7'b0100100: dnib = 4'h2;
      7'b0110000: dnib = 4'h3;
      7'b0011001: dnib = 4'h4;
      7'b0010010: dnib = 4'h5;
      7'b0000010: dnib = 4'h6;
      7'b1111000: dnib = 4'h7;
      7'b0000000: dnib = 4'h8;
      7'b0010000: dnib = 4'h9;
      7'b0001000: dnib = 4'hA;
      7'b0000011: dnib = 4'hB;
      7'b1000110: dnib = 4'hC;
      7'b0100001: dnib = 4'hD;
      7'b0000110: dnib = 4'hE;
      7'b0001110: dnib = 4'hF;
      default:    dbad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= '1;
      an_p  <= '1;
      seg_q <= '1;
      seg_p <= '1;
      cnt   <= '0;
      dwell <= 1'b0;
    end else begin
      an_q  <= an;
      seg_q <= seg;
      an_p  <= an_q;
      seg_p <= seg_q;
      if (!onehot) begin
        cnt   <= '0;
        dwell <= 1'b0;
      end else if (!same) begin
        cnt   <= CW'(1);
        dwell <= 1'b0;
      end else begin
        if (cnt != SMAX)
          cnt <= cnt + CW'(1);
        if (cap)
          dwell <= 1'b1;
      end
    end
  end

  // Completion clears the mask; a same-cycle capture opens the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
      sbad <= '0;
      snib <= '0;
    end else begin
      mask <= (done ? '0 : mask) | (cap ? sel : '0);
      for (int k = 0; k < NDIG; k++) begin
        if (cap && sel[k]) begin
          snib[4*k +: 4] <= dnib;
          sbad[k]        <= dbad;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      digit_err   <= '0;
    end else begin
      frame_valid <= done;
      if (done) begin
        value     <= snib;
        digit_err <= sbad;
        frame_err <= |sbad;
      end
    end
  end

endmodule
